// File: rtl/if_fetch_stage.sv
// Instruction fetch: owns PC, drives sync imem, presents {ir, ir_pc4} to decode; optional counters via IF_PERF_CNT_EN.
// Latency: first ir_valid 3 cycles after reset release; one instruction per 3 cycles (non-overlapped).
// Backpressure: holds ir/ir_pc4/ir_valid stable with no imem access while ir_ready=0; redirect > flush > handshake.
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        PCWre,
    input  logic        IRWre,
    input  logic [1:0]  Branch,
    input  logic        zero,
    input  logic [31:0] br_pc4,
    input  logic [31:0] br_offset,
    input  logic [25:0] j_target,
    input  logic [31:0] rs_val,
    input  logic        flush,
    output logic [31:0] imem_addr,
    output logic        imem_en,
    input  logic [31:0] imem_rdata,
    output logic [31:0] ir,
    output logic [31:0] ir_pc4,
    output logic        ir_valid,
`ifdef IF_PERF_CNT_EN
    output logic [31:0] fetch_cnt,
    output logic [31:0] redirect_cnt,
`endif
    input  logic        ir_ready
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_HOLD  = 2'd3;

    logic [1:0]  r_state;
    logic [31:0] r_pc;
    logic [31:0] r_ir;
    logic [31:0] r_ir_pc4;
    logic        r_ir_valid;

    logic        w_redirect;
    logic        w_active;
    logic        w_take_redirect;
    logic        w_take_flush;
    logic        w_handshake;
    logic [31:0] w_target;
    logic [31:0] w_pc_plus4;
    logic [31:0] w_br_off_shl;

    assign w_pc_plus4   = r_pc + 32'd4;
    assign w_br_off_shl = br_offset << 2;
    assign w_active     = (r_state != S_IDLE);
    assign w_redirect   = PCWre && ((Branch == 2'b01 && zero) || Branch[1]);

    // Redirects and flushes only act once the fetch loop is running.
    assign w_take_redirect = w_redirect && w_active;
    assign w_take_flush    = flush && !w_redirect && w_active;
    assign w_handshake     = (r_state == S_HOLD) && r_ir_valid && ir_ready
                             && !w_redirect && !flush;

    always_comb begin
        w_target = rs_val & 32'hFFFF_FFFC;
        case (Branch)
            2'b01:   w_target = br_pc4 + w_br_off_shl;
            2'b10:   w_target = {br_pc4[31:28], j_target, 2'b00};
            default: w_target = rs_val & 32'hFFFF_FFFC;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_pc       <= RESET_PC;
            r_ir       <= 32'd0;
            r_ir_pc4   <= 32'd0;
            r_ir_valid <= 1'b0;
        end else if (!w_active) begin
            r_state <= S_FETCH;
        end else if (w_take_redirect) begin
            // Any word in flight from imem belongs to the old stream and is dropped.
            r_pc       <= w_target;
            r_ir_valid <= 1'b0;
            r_state    <= S_FETCH;
        end else if (w_take_flush) begin
            r_ir_valid <= 1'b0;
            r_state    <= S_FETCH;
        end else begin
            case (r_state)
                S_FETCH: r_state <= S_DATA;
                S_DATA: begin
                    if (IRWre) begin
                        r_ir       <= imem_rdata;
                        r_ir_pc4   <= w_pc_plus4;
                        r_ir_valid <= 1'b1;
                        r_state    <= S_HOLD;
                    end else begin
                        r_state <= S_FETCH;
                    end
                end
                S_HOLD: begin
                    if (w_handshake) begin
                        r_ir_valid <= 1'b0;
                        r_pc       <= w_pc_plus4;
                        r_state    <= S_FETCH;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifdef IF_PERF_CNT_EN
    logic [31:0] r_fetch_cnt;
    logic [31:0] r_redirect_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_fetch_cnt    <= 32'd0;
            r_redirect_cnt <= 32'd0;
        end else begin
            if (w_handshake)
                r_fetch_cnt <= r_fetch_cnt + 32'd1;
            if (w_take_redirect)
                r_redirect_cnt <= r_redirect_cnt + 32'd1;
        end
    end

    assign fetch_cnt    = r_fetch_cnt;
    assign redirect_cnt = r_redirect_cnt;
`endif

    assign imem_addr = r_pc;
    assign imem_en   = (r_state == S_FETCH);
    assign ir        = r_ir;
    assign ir_pc4    = r_ir_pc4;
    assign ir_valid  = r_ir_valid;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage: main instance at RESET_PC=0, second instance at RESET_PC=FFFF_FFFC for wrap/reset cases.
module tb_if_fetch_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        rst_w;
    logic        PCWre, IRWre, zero, flush, ir_ready;
    logic [1:0]  Branch;
    logic [31:0] br_pc4, br_offset, rs_val;
    logic [25:0] j_target;

    logic [31:0] imem_addr, imem_rdata, ir, ir_pc4;
    logic        imem_en, ir_valid;
    logic [31:0] imem_addr_w, imem_rdata_w, ir_w, ir_pc4_w;
    logic        imem_en_w, ir_valid_w;
`ifdef IF_PERF_CNT_EN
    logic [31:0] fetch_cnt, redirect_cnt, fetch_cnt_w, redirect_cnt_w;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    if_fetch_stage #(.RESET_PC(32'h0000_0000)) u_dut (
        .clk(clk), .rst(rst), .PCWre(PCWre), .IRWre(IRWre), .Branch(Branch), .zero(zero),
        .br_pc4(br_pc4), .br_offset(br_offset), .j_target(j_target), .rs_val(rs_val),
        .flush(flush), .imem_addr(imem_addr), .imem_en(imem_en), .imem_rdata(imem_rdata),
        .ir(ir), .ir_pc4(ir_pc4), .ir_valid(ir_valid),
`ifdef IF_PERF_CNT_EN
        .fetch_cnt(fetch_cnt), .redirect_cnt(redirect_cnt),
`endif
        .ir_ready(ir_ready)
    );

    if_fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
        .clk(clk), .rst(rst_w), .PCWre(PCWre), .IRWre(IRWre), .Branch(Branch), .zero(zero),
        .br_pc4(br_pc4), .br_offset(br_offset), .j_target(j_target), .rs_val(rs_val),
        .flush(flush), .imem_addr(imem_addr_w), .imem_en(imem_en_w), .imem_rdata(imem_rdata_w),
        .ir(ir_w), .ir_pc4(ir_pc4_w), .ir_valid(ir_valid_w),
`ifdef IF_PERF_CNT_EN
        .fetch_cnt(fetch_cnt_w), .redirect_cnt(redirect_cnt_w),
`endif
        .ir_ready(ir_ready)
    );

    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        return (a == 32'd0) ? 32'h2001_0005 : (a ^ 32'h8C00_0000);
    endfunction

    always @(posedge clk) begin
        if (imem_en)   imem_rdata   <= mem_fn(imem_addr);
        if (imem_en_w) imem_rdata_w <= mem_fn(imem_addr_w);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic no_redirect();
        PCWre = 1'b0; Branch = 2'b00; zero = 1'b0; flush = 1'b0;
    endtask

    initial begin
        rst = 1'b0; rst_w = 1'b0;
        IRWre = 1'b1; ir_ready = 1'b1;
        br_pc4 = '0; br_offset = '0; j_target = '0; rs_val = '0;
        no_redirect();
        repeat (3) @(negedge clk);

        chk("rst_ir_valid", {31'd0, ir_valid}, 32'd0);
        chk("rst_ir", ir, 32'd0);
        chk("rst_ir_pc4", ir_pc4, 32'd0);
        chk("rst_imem_en", {31'd0, imem_en}, 32'd0);
        chk("rst_addr", imem_addr, 32'd0);

        // 1: first fetch
        rst = 1'b1;
        chk("t1_c0_en", {31'd0, imem_en}, 32'd0);
        tick();
        chk("t1_c1_en", {31'd0, imem_en}, 32'd1);
        chk("t1_c1_addr", imem_addr, 32'd0);
        tick();
        chk("t1_c2_en", {31'd0, imem_en}, 32'd0);
        chk("t1_c2_valid", {31'd0, ir_valid}, 32'd0);
        tick();
        chk("t1_c3_valid", {31'd0, ir_valid}, 32'd1);
        chk("t1_c3_ir", ir, 32'h2001_0005);
        chk("t1_c3_pc4", ir_pc4, 32'd4);
        tick();
        chk("t1_next_addr", imem_addr, 32'd4);
        chk("t1_next_valid", {31'd0, ir_valid}, 32'd0);
        chk("t1_next_en", {31'd0, imem_en}, 32'd1);

        // 2: backpressure in HOLD
        ir_ready = 1'b0;
        tick(); tick();
        for (int i = 0; i < 10; i++) begin
            chk("t2_hold_valid", {31'd0, ir_valid}, 32'd1);
            chk("t2_hold_ir", ir, 32'h8C00_0004);
            chk("t2_hold_pc4", ir_pc4, 32'd8);
            chk("t2_hold_en", {31'd0, imem_en}, 32'd0);
            tick();
        end
        ir_ready = 1'b1;
        tick();
        chk("t2_release_addr", imem_addr, 32'd8);
        chk("t2_release_valid", {31'd0, ir_valid}, 32'd0);

        // 3: advance to pc=C, then taken / not-taken beq from HOLD and FETCH
        tick(); tick(); tick();
        chk("t3_pre_addr", imem_addr, 32'h0C);
        ir_ready = 1'b0;
        tick(); tick();
        chk("t3_hold_valid", {31'd0, ir_valid}, 32'd1);
        PCWre = 1'b1; Branch = 2'b01; zero = 1'b1;
        br_pc4 = 32'h10; br_offset = 32'hFFFF_FFFE;
        tick();
        chk("t3_beq_addr", imem_addr, 32'h08);
        chk("t3_beq_valid", {31'd0, ir_valid}, 32'd0);
        chk("t3_beq_en", {31'd0, imem_en}, 32'd1);
        zero = 1'b0;
        tick();
        chk("t3_nt_addr", imem_addr, 32'h08);
        chk("t3_nt_en", {31'd0, imem_en}, 32'd0);
        Branch = 2'b00;
        tick();
        chk("t3_seq_valid", {31'd0, ir_valid}, 32'd1);
        chk("t3_seq_ir", ir, 32'h8C00_0008);
        chk("t3_seq_addr", imem_addr, 32'h08);

        // 4: jump from HOLD, then jump-register from FETCH
        Branch = 2'b10; br_pc4 = 32'h4000_0010; j_target = 26'h000_0040;
        tick();
        chk("t4_j_addr", imem_addr, 32'h4000_0100);
        chk("t4_j_valid", {31'd0, ir_valid}, 32'd0);
        Branch = 2'b11; rs_val = 32'h0000_0123;
        tick();
        chk("t4_jr_addr", imem_addr, 32'h0000_0120);
        chk("t4_jr_en", {31'd0, imem_en}, 32'd1);
        no_redirect();

        // 5: redirect + flush + handshake together, then flush in DATA, then IRWre=0 in DATA
        tick(); tick();
        chk("t5_hold_valid", {31'd0, ir_valid}, 32'd1);
        chk("t5_hold_pc4", ir_pc4, 32'h124);
        ir_ready = 1'b1; flush = 1'b1;
        PCWre = 1'b1; Branch = 2'b10; br_pc4 = 32'h0; j_target = 26'h10;
        tick();
        chk("t5_prio_addr", imem_addr, 32'h40);
        chk("t5_prio_valid", {31'd0, ir_valid}, 32'd0);
        no_redirect();
        ir_ready = 1'b0;
        tick();
        chk("t5_data_en", {31'd0, imem_en}, 32'd0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("t5_flush_addr", imem_addr, 32'h40);
        chk("t5_flush_en", {31'd0, imem_en}, 32'd1);
        chk("t5_flush_valid", {31'd0, ir_valid}, 32'd0);
        tick();
        IRWre = 1'b0;
        tick();
        IRWre = 1'b1;
        chk("t5_irwre_en", {31'd0, imem_en}, 32'd1);
        chk("t5_irwre_addr", imem_addr, 32'h40);
        chk("t5_irwre_valid", {31'd0, ir_valid}, 32'd0);

`ifdef IF_PERF_CNT_EN
        chk("cnt_fetch", fetch_cnt, 32'd3);
        chk("cnt_redirect", redirect_cnt, 32'd4);
`endif

        // 6: wrap instance and asynchronous reset in HOLD
        ir_ready = 1'b1;
        rst_w = 1'b1;
        tick(); tick(); tick();
        chk("t6_wrap_valid", {31'd0, ir_valid_w}, 32'd1);
        chk("t6_wrap_pc4", ir_pc4_w, 32'd0);
        chk("t6_wrap_ir", ir_w, 32'h73FF_FFFC);
        tick();
        chk("t6_wrap_addr", imem_addr_w, 32'd0);
        ir_ready = 1'b0;
        tick(); tick();
        chk("t6_hold_valid", {31'd0, ir_valid_w}, 32'd1);
        #2 rst_w = 1'b0;
        #1;
        chk("t6_arst_valid", {31'd0, ir_valid_w}, 32'd0);
        chk("t6_arst_addr", imem_addr_w, 32'hFFFF_FFFC);
        chk("t6_arst_en", {31'd0, imem_en_w}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
